// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CNT machine performance counters (mhpmcounter3..) with per-counter event selectors.
// Optional overflow flag and interrupt (Sscofpmf-style) are enabled by defining HPM_OVF_IRQ_EN.
module hpm_counter_bank #(
    parameter int NUM_CNT    = 6,
    parameter int NUM_EVENTS = 32,
    parameter int EVT_SEL_W  = 5,
    parameter int INC_W      = 2,
    parameter int CNT_W      = 64,
    parameter int XLEN       = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        debug_mode_i,
    input  logic [11:0]                 csr_addr_i,
    input  logic                        csr_re_i,
    input  logic                        csr_we_i,
    input  logic [XLEN-1:0]             csr_wdata_i,
    output logic [XLEN-1:0]             csr_rdata_o,
    output logic                        csr_err_o,
    input  logic [NUM_EVENTS*INC_W-1:0] event_inc_i,
    input  logic [NUM_CNT-1:0]          inhibit_i,
    output logic                        ovf_irq_o
);

    logic [CNT_W-1:0]     cnt_q [NUM_CNT];
    logic [CNT_W-1:0]     cnt_d [NUM_CNT];
    logic [EVT_SEL_W-1:0] sel_q [NUM_CNT];
    logic [EVT_SEL_W-1:0] sel_d [NUM_CNT];
    logic [NUM_CNT-1:0]   of_q;

    logic [NUM_CNT-1:0]   hit_lo, hit_hi, hit_evt, cnt_wr;
    logic                 strobe, valid, is_user, wr;
    logic [63:0]          wdata64;
    logic [63:0]          cnt_ext [NUM_CNT];
    logic [63:0]          wnew    [NUM_CNT];
    logic [INC_W-1:0]     inc     [NUM_CNT];
    logic [CNT_W:0]       sum     [NUM_CNT];
    logic [XLEN-1:0]      evt_v;

    assign strobe  = csr_re_i | csr_we_i;
    assign wdata64 = 64'(csr_wdata_i);

    // Low-half hits cover both the machine and the read-only user alias.
    always_comb begin
        hit_lo  = '0;
        hit_hi  = '0;
        hit_evt = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (csr_addr_i == 12'hB03 + 12'(i) || csr_addr_i == 12'hC03 + 12'(i))
                hit_lo[i] = 1'b1;
            if (XLEN == 32 && (csr_addr_i == 12'hB83 + 12'(i) || csr_addr_i == 12'hC83 + 12'(i)))
                hit_hi[i] = 1'b1;
            if (csr_addr_i == 12'h323 + 12'(i))
                hit_evt[i] = 1'b1;
        end
    end

    assign valid     = |{hit_lo, hit_hi, hit_evt};
    assign is_user   = (csr_addr_i[11:8] == 4'hC);
    assign csr_err_o = strobe & (~valid | (csr_we_i & is_user));
    assign wr        = csr_we_i & ~csr_err_o;

    always_comb begin
        csr_rdata_o = '0;
        evt_v       = '0;
        if (csr_re_i && !csr_err_o) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                evt_v                  = '0;
                evt_v[EVT_SEL_W-1:0]   = sel_q[i];
                evt_v[XLEN-1]          = of_q[i];
                if (hit_lo[i])  csr_rdata_o = XLEN'(cnt_ext[i]);
                if (hit_hi[i])  csr_rdata_o = XLEN'(cnt_ext[i][63:32]);
                if (hit_evt[i]) csr_rdata_o = evt_v;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_ext[i] = 64'(cnt_q[i]);
            inc[i]     = '0;
            if (!debug_mode_i && !inhibit_i[i]) begin
                for (int e = 1; e < NUM_EVENTS; e++) begin
                    if (sel_q[i] == EVT_SEL_W'(e))
                        inc[i] = event_inc_i[e*INC_W +: INC_W];
                end
            end
            sum[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(inc[i]);

            wnew[i] = wdata64;
            if (XLEN == 32 && hit_lo[i]) wnew[i] = {cnt_ext[i][63:32], wdata64[31:0]};
            if (hit_hi[i])               wnew[i] = {wdata64[31:0], cnt_ext[i][31:0]};

            cnt_wr[i] = wr & (hit_lo[i] | hit_hi[i]);
            cnt_d[i]  = cnt_wr[i] ? wnew[i][CNT_W-1:0] : sum[i][CNT_W-1:0];
            sel_d[i]  = (wr && hit_evt[i]) ? csr_wdata_i[EVT_SEL_W-1:0] : sel_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
        end
    end

`ifdef HPM_OVF_IRQ_EN
    logic [NUM_CNT-1:0] of_d;
    logic               irq_q;

    // A counting carry beats a clearing write; a counter write drops the increment, so it cannot overflow.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            of_d[i] = of_q[i];
            if (wr && hit_evt[i])            of_d[i] = csr_wdata_i[XLEN-1];
            if (!cnt_wr[i] && sum[i][CNT_W]) of_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            of_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            of_q  <= of_d;
            irq_q <= |of_q;
        end
    end

    assign ovf_irq_o = irq_q;
`else
    assign of_q      = '0;
    assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed self-checking bench for hpm_counter_bank (XLEN=64, CNT_W=64, INC_W=2).
// Overflow expectations follow whether HPM_OVF_IRQ_EN is defined for the build.
module tb_hpm_counter_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        debug;
    logic [11:0] addr;
    logic        re, we;
    logic [63:0] wdata, rdata;
    logic        err;
    logic [63:0] evt;
    logic [5:0]  inh;
    logic        irq;

    int total = 0;
    int bad   = 0;

    hpm_counter_bank #(
        .NUM_CNT(6), .NUM_EVENTS(32), .EVT_SEL_W(5), .INC_W(2), .CNT_W(64), .XLEN(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug),
        .csr_addr_i(addr), .csr_re_i(re), .csr_we_i(we), .csr_wdata_i(wdata),
        .csr_rdata_o(rdata), .csr_err_o(err), .event_inc_i(evt),
        .inhibit_i(inh), .ovf_irq_o(irq)
    );

    always #5 clk = ~clk;

    // Combinational read; caller places it in a low clock phase.
    task automatic do_read(input logic [11:0] a, output logic [63:0] d, output logic e);
        addr = a;
        re   = 1'b1;
        #1;
        d    = rdata;
        e    = err;
        re   = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d, output logic e);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        #1;
        e = err;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic set_evt(input int e, input logic [1:0] v);
        evt[e*2 +: 2] = v;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic        e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err_idle: got %b want 0", err); end
        total++;
        if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata_idle: got %h want 0", rdata); end
        for (int i = 0; i < 6; i++) begin
            do_read(12'hB03 + 12'(i), d, e);
            total++;
            if (d !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_mhpmcounter%0d: got %h err %b want 0 err 0", i+3, d, e); end
            do_read(12'hC03 + 12'(i), d, e);
            total++;
            if (d !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_hpmcounter%0d: got %h err %b want 0 err 0", i+3, d, e); end
            do_read(12'h323 + 12'(i), d, e);
            total++;
            if (d !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL reset_mhpmevent%0d: got %h err %b want 0 err 0", i+3, d, e); end
        end
    endtask

    task automatic test_counting();
        logic [63:0] d;
        logic        e;
        do_write(12'h323, 64'd5, e);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL cnt_sel_write_err: got %b want 0", e); end
        @(negedge clk);
        set_evt(5, 2'd3);
        set_evt(0, 2'd3);
        repeat (4) @(negedge clk);
        set_evt(5, 2'd0);
        set_evt(0, 2'd0);
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'd12) begin bad++; $display("FAIL cnt_mhpmcounter3: got %0d want 12", d); end
        do_read(12'hC03, d, e);
        total++;
        if (d !== 64'd12) begin bad++; $display("FAIL cnt_hpmcounter3: got %0d want 12", d); end
        do_read(12'h323, d, e);
        total++;
        if (d !== 64'd5) begin bad++; $display("FAIL cnt_mhpmevent3: got %h want 5", d); end
        do_read(12'hB04, d, e);
        total++;
        if (d !== 64'd0) begin bad++; $display("FAIL cnt_event0_never: got %0d want 0", d); end
    endtask

    task automatic test_inhibit_debug();
        logic [63:0] d;
        logic        e;
        do_write(12'hB03, 64'd0, e);
        do_write(12'h324, 64'd5, e);
        @(negedge clk);
        inh = 6'b000010;
        set_evt(5, 2'd1);
        repeat (5) @(negedge clk);
        inh   = 6'b0;
        debug = 1'b1;
        repeat (5) @(negedge clk);
        set_evt(5, 2'd0);
        debug = 1'b0;
        @(negedge clk);
        do_read(12'hB04, d, e);
        total++;
        if (d !== 64'd0) begin bad++; $display("FAIL inh_counter4: got %0d want 0", d); end
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'd5) begin bad++; $display("FAIL inh_counter3_free: got %0d want 5", d); end
    endtask

    task automatic test_write_precedence();
        logic [63:0] d;
        logic        e;
        do_write(12'h323, 64'd2, e);
        do_write(12'h324, 64'd2, e);
        do_write(12'hB03, 64'd0, e);
        do_write(12'hB04, 64'd0, e);
        @(negedge clk);
        set_evt(2, 2'd1);
        repeat (3) @(posedge clk);
        do_write(12'hB03, 64'd100, e);
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'd100) begin bad++; $display("FAIL prec_cnt3_written: got %0d want 100", d); end
        do_read(12'hB04, d, e);
        total++;
        if (d !== 64'd4) begin bad++; $display("FAIL prec_cnt4_counts: got %0d want 4", d); end
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'd101) begin bad++; $display("FAIL prec_cnt3_resume: got %0d want 101", d); end
        do_read(12'hB04, d, e);
        total++;
        if (d !== 64'd5) begin bad++; $display("FAIL prec_cnt4_next: got %0d want 5", d); end
        set_evt(2, 2'd0);
        do_write(12'h323, 64'd0, e);
        do_write(12'h324, 64'd0, e);
    endtask

    task automatic test_illegal();
        logic [63:0] d;
        logic        e;
        do_write(12'hB03, 64'h55, e);
        do_write(12'hC03, 64'h77, e);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL ill_write_c03_err: got %b want 1", e); end
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'h55) begin bad++; $display("FAIL ill_write_c03_state: got %h want 55", d); end
        do_read(12'hB83, d, e);
        total++;
        if (e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL ill_read_b83: err %b data %h want err 1 data 0", e, d); end
        do_read(12'hB09, d, e);
        total++;
        if (e !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL ill_read_b09: err %b data %h want err 1 data 0", e, d); end
        do_read(12'hB08, d, e);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL ill_read_b08_legal: err %b want 0", e); end
        do_write(12'hB83, 64'h1234, e);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL ill_write_b83_err: got %b want 1", e); end
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'h55) begin bad++; $display("FAIL ill_write_b83_state: got %h want 55", d); end
        // Simultaneous read and write returns the old value.
        @(negedge clk);
        addr  = 12'hB03;
        wdata = 64'h99;
        we    = 1'b1;
        re    = 1'b1;
        #1;
        total++;
        if (rdata !== 64'h55) begin bad++; $display("FAIL rw_same_cycle_old: got %h want 55", rdata); end
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
        @(negedge clk);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'h99) begin bad++; $display("FAIL rw_same_cycle_new: got %h want 99", d); end
    endtask

    task automatic test_overflow();
        logic [63:0] d;
        logic        e;
        logic [63:0] of_exp;
        logic        irq_exp;
`ifdef HPM_OVF_IRQ_EN
        of_exp  = 64'h8000_0000_0000_0001;
        irq_exp = 1'b1;
`else
        of_exp  = 64'h1;
        irq_exp = 1'b0;
`endif
        do_write(12'h323, 64'd1, e);
        do_write(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE, e);
        @(negedge clk);
        do_read(12'h323, d, e);
        total++;
        if (d !== 64'h1) begin bad++; $display("FAIL ovf_write_no_of: got %h want 1", d); end
        set_evt(1, 2'd3);
        @(posedge clk);
        #1;
        set_evt(1, 2'd0);
        do_read(12'hB03, d, e);
        total++;
        if (d !== 64'h1) begin bad++; $display("FAIL ovf_wrap: got %h want 1", d); end
        do_read(12'h323, d, e);
        total++;
        if (d !== of_exp) begin bad++; $display("FAIL ovf_of_set: got %h want %h", d, of_exp); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_delay: got %b want 0", irq); end
        @(posedge clk);
        #1;
        total++;
        if (irq !== irq_exp) begin bad++; $display("FAIL ovf_irq_rise: got %b want %b", irq, irq_exp); end
        do_write(12'h323, 64'd1, e);
        do_read(12'h323, d, e);
        total++;
        if (d !== 64'h1) begin bad++; $display("FAIL ovf_of_clear: got %h want 1", d); end
        total++;
        if (irq !== irq_exp) begin bad++; $display("FAIL ovf_irq_hold: got %b want %b", irq, irq_exp); end
        @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL ovf_irq_fall: got %b want 0", irq); end
    endtask

    initial begin
        rst_n = 1'b0;
        debug = 1'b0;
        addr  = 12'h0;
        re    = 1'b0;
        we    = 1'b0;
        wdata = 64'h0;
        evt   = 64'h0;
        inh   = 6'b0;
        test_reset();
        test_counting();
        test_inhibit_debug();
        test_write_precedence();
        test_illegal();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
